// File: rtl/mpq_defs.sv
// mpq_defs: shared definitions for the multi-port queue slice.
//   LANE_CNT_W  width of the per-cycle push/pop lane count inputs.
//   MPQ_DEPTH   ring depth for a given index width (1 << aw). It is named
//               this way so it does not collide with the existing MAX_BUF.
`ifndef MPQ_DEFS_SV
`define MPQ_DEFS_SV

`define MPQ_DEPTH(aw) (1 << (aw))

package mpq_defs;
  localparam int LANE_CNT_W = 3;
endpackage

`endif

// File: rtl/mpq_ring_add.sv
// mpq_ring_add: combinational ring-pointer add, (ptr + step) mod DEPTH.
// The addition is done in ADDR_WIDTH bits, so wrap-around falls out of the
// truncation.
// Ports:
//   ptr_IN   base pointer (ADDR_WIDTH)
//   step_IN  distance to add (LANE_CNT_W)
//   sum_OUT  wrapped result (ADDR_WIDTH)
module mpq_ring_add
  import mpq_defs::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] ptr_IN,
  input  logic [LANE_CNT_W-1:0] step_IN,
  output logic [ADDR_WIDTH-1:0] sum_OUT
);

  assign sum_OUT = ptr_IN + ADDR_WIDTH'(step_IN);

endmodule

// File: rtl/multi_port_queue.sv
// multi_port_queue: circular FIFO that takes up to PUSH_LANES entries and
// retires up to POP_LANES entries per cycle. It also provides occupancy
// outputs, an almost-full threshold, tail rollback for mispredict recovery,
// and a flush.
// Optional macro: MULTI_PORT_QUEUE_PROBE_EN adds a random-access probe
// read/write port.
// Ports:
//   clk, reset            clock (posedge) and asynchronous active-low reset
//   flush_IN              clear head/tail/count; buffer contents are kept
//   pushCount_IN/data_IN  push offer; lane i is data_IN[i*DW +: DW]
//   pushAck_OUT           whole offer accepted (combinational)
//   pushOverflow_OUT      debug: pushCount_IN > PUSH_LANES (treated as 0)
//   popCount_IN           requested pops; data_OUT/popValid_OUT read from head
//   rollback_IN/rollbackTail_IN  restore tail; count is recomputed from head
//   count_OUT, freeCount_OUT, emptyFlag_OUT, fullFlag_OUT, almostFull_OUT
//   curHead_OUT, curTail_OUT
//   probeIdx_IN, probeData_OUT, probePushReq_IN, probeData_IN (probe build only)
//
// Handshake: a push is offered when pushCount_IN != 0. pushAck_OUT is the
// same-cycle ready, and the transfer completes at the edge where both hold.
// The offer is all-or-none. Free space is judged before this cycle's pops.
// pushAck_OUT only reports eligibility: during a flush or rollback cycle
// nothing is written even when it is high. Pops are unconditional. Up to
// popCount_IN of the popValid_OUT lanes retire at the edge.
module multi_port_queue
  import mpq_defs::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int PUSH_LANES   = 2,
  parameter int POP_LANES    = 2,
  parameter int AFULL_THRESH = `MPQ_DEPTH(ADDR_WIDTH) - 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_IN,
  input  logic [LANE_CNT_W-1:0]            pushCount_IN,
  input  logic [PUSH_LANES*DATA_WIDTH-1:0] data_IN,
  output logic                             pushAck_OUT,
  output logic                             pushOverflow_OUT,
  input  logic [LANE_CNT_W-1:0]            popCount_IN,
  output logic [POP_LANES*DATA_WIDTH-1:0]  data_OUT,
  output logic [POP_LANES-1:0]             popValid_OUT,
  input  logic                             rollback_IN,
  input  logic [ADDR_WIDTH-1:0]            rollbackTail_IN,
`ifdef MULTI_PORT_QUEUE_PROBE_EN
  input  logic [ADDR_WIDTH-1:0]            probeIdx_IN,
  output logic [DATA_WIDTH-1:0]            probeData_OUT,
  input  logic                             probePushReq_IN,
  input  logic [DATA_WIDTH-1:0]            probeData_IN,
`endif
  output logic [ADDR_WIDTH:0]              count_OUT,
  output logic [ADDR_WIDTH:0]              freeCount_OUT,
  output logic                             emptyFlag_OUT,
  output logic                             fullFlag_OUT,
  output logic                             almostFull_OUT,
  output logic [ADDR_WIDTH-1:0]            curHead_OUT,
  output logic [ADDR_WIDTH-1:0]            curTail_OUT
);

  localparam int DEPTH = `MPQ_DEPTH(ADDR_WIDTH);
  localparam int CNT_W = ADDR_WIDTH + 1;
  // Common width for comparing lane counts against occupancy counts.
  localparam int CMP_W = (CNT_W > LANE_CNT_W) ? CNT_W : LANE_CNT_W;

  logic [ADDR_WIDTH-1:0] head, tail, headNext, tailNext, rbSpan;
  logic [CNT_W-1:0]      count, freeCount;
  logic [DATA_WIDTH-1:0] buffer [DEPTH];
  logic [LANE_CNT_W-1:0] pushed, popReq, popped;
  logic                  doPush;
  logic [ADDR_WIDTH-1:0] wrIdx [PUSH_LANES];
  logic [ADDR_WIDTH-1:0] rdIdx [POP_LANES];

  assign freeCount        = CNT_W'(DEPTH) - count;
  assign pushOverflow_OUT = pushCount_IN > LANE_CNT_W'(PUSH_LANES);
  assign pushAck_OUT      = !pushOverflow_OUT && (pushCount_IN != '0) &&
                            (CMP_W'(pushCount_IN) <= CMP_W'(freeCount));
  assign doPush           = pushAck_OUT && !flush_IN && !rollback_IN;
  assign pushed           = doPush ? pushCount_IN : '0;

  // popped = min(popCount_IN, POP_LANES, count)
  assign popReq = (popCount_IN > LANE_CNT_W'(POP_LANES)) ? LANE_CNT_W'(POP_LANES) : popCount_IN;
  assign popped = (CMP_W'(popReq) <= CMP_W'(count)) ? popReq : LANE_CNT_W'(count);

  for (genvar i = 0; i < PUSH_LANES; i++) begin : g_wr
    mpq_ring_add #(.ADDR_WIDTH(ADDR_WIDTH)) u_wrAdd (
      .ptr_IN(tail), .step_IN(LANE_CNT_W'(i)), .sum_OUT(wrIdx[i])
    );
  end

  for (genvar i = 0; i < POP_LANES; i++) begin : g_rd
    mpq_ring_add #(.ADDR_WIDTH(ADDR_WIDTH)) u_rdAdd (
      .ptr_IN(head), .step_IN(LANE_CNT_W'(i)), .sum_OUT(rdIdx[i])
    );
    assign data_OUT[i*DATA_WIDTH +: DATA_WIDTH] = buffer[rdIdx[i]];
    assign popValid_OUT[i] = count > CNT_W'(i);
  end

  mpq_ring_add #(.ADDR_WIDTH(ADDR_WIDTH)) u_tailAdv (
    .ptr_IN(tail), .step_IN(pushed), .sum_OUT(tailNext)
  );
  mpq_ring_add #(.ADDR_WIDTH(ADDR_WIDTH)) u_headAdv (
    .ptr_IN(head), .step_IN(popped), .sum_OUT(headNext)
  );

  // A rollback to tail == head gives span 0 (empty). A full ring is never
  // reconstructed from a rollback.
  assign rbSpan = rollbackTail_IN - head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_IN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rollback_IN) begin
      tail  <= rollbackTail_IN;
      count <= {1'b0, rbSpan};
    end else begin
      head  <= headNext;
      tail  <= tailNext;
      count <= count + CNT_W'(pushed) - CNT_W'(popped);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      if (doPush) begin
        for (int i = 0; i < PUSH_LANES; i++) begin
          if (LANE_CNT_W'(i) < pushCount_IN)
            buffer[wrIdx[i]] <= data_IN[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`ifdef MULTI_PORT_QUEUE_PROBE_EN
      // Placed after the lane writes so a probe to the same index wins.
      if (probePushReq_IN) buffer[probeIdx_IN] <= probeData_IN;
`endif
    end
  end

`ifdef MULTI_PORT_QUEUE_PROBE_EN
  assign probeData_OUT = buffer[probeIdx_IN];
`endif

  assign count_OUT      = count;
  assign freeCount_OUT  = freeCount;
  assign emptyFlag_OUT  = (count == '0);
  assign fullFlag_OUT   = (count == CNT_W'(DEPTH));
  assign almostFull_OUT = (count >= CNT_W'(AFULL_THRESH));
  assign curHead_OUT    = head;
  assign curTail_OUT    = tail;

endmodule

// File: tb/tb_multi_port_queue.sv
module tb_multi_port_queue;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0, rollback = 1'b0;
  logic [2:0] pushCount = '0, popCount = '0, rbTail = '0;
  logic [2*DW-1:0] dataIn = '0, dataOut;
  logic pushAck, pushOverflow;
  logic [1:0] popValid;
  logic [AW:0] count, freeCount;
  logic empty, full, afull;
  logic [AW-1:0] head, tail;
`ifdef MULTI_PORT_QUEUE_PROBE_EN
  logic [AW-1:0] probeIdx = '0;
  logic [DW-1:0] probeDataOut, probeDataIn = '0;
  logic probeReq = 1'b0;
`endif

  always #5 clk = ~clk;

  multi_port_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PUSH_LANES(2), .POP_LANES(2), .AFULL_THRESH(6)
  ) dut (
    .clk(clk), .reset(reset), .flush_IN(flush),
    .pushCount_IN(pushCount), .data_IN(dataIn), .pushAck_OUT(pushAck),
    .pushOverflow_OUT(pushOverflow), .popCount_IN(popCount),
    .data_OUT(dataOut), .popValid_OUT(popValid),
    .rollback_IN(rollback), .rollbackTail_IN(rbTail),
`ifdef MULTI_PORT_QUEUE_PROBE_EN
    .probeIdx_IN(probeIdx), .probeData_OUT(probeDataOut),
    .probePushReq_IN(probeReq), .probeData_IN(probeDataIn),
`endif
    .count_OUT(count), .freeCount_OUT(freeCount), .emptyFlag_OUT(empty),
    .fullFlag_OUT(full), .almostFull_OUT(afull),
    .curHead_OUT(head), .curTail_OUT(tail)
  );

  // ---------------- reference model + scoreboard ----------------
  int vecs = 0, miscompares = 0;
  logic [DW-1:0] mem [DEPTH];   // physical storage image
  int mHead, mCnt;              // tail is always (mHead + mCnt) % DEPTH
  logic [DW-1:0] exp_q[$];      // live entries, oldest first

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mHead = 0;
    mCnt = 0;
    exp_q.delete();
  endtask

  task automatic check_state();
    check("count", count, mCnt);
    check("freeCount", freeCount, DEPTH - mCnt);
    check("empty", empty, mCnt == 0);
    check("full", full, mCnt == DEPTH);
    check("almostFull", afull, mCnt >= 6);
    check("head", head, mHead);
    check("tail", tail, (mHead + mCnt) % DEPTH);
    check("popValid", popValid, {mCnt > 1, mCnt > 0});
    check("data_OUT", dataOut, {mem[(mHead + 1) % DEPTH], mem[mHead]});
  endtask

  // Driver: apply one cycle of inputs, check combinational outputs before the
  // edge, advance the model at the edge, then check the registered state.
  task automatic step(input logic fl, input logic rb, input logic [2:0] rbT,
                      input logic [2:0] pn, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [2:0] qn);
    int popped, pushed, pos;
    bit ack;
    logic [7:0] lane;
    flush = fl; rollback = rb; rbTail = rbT;
    pushCount = pn; dataIn = {d1, d0}; popCount = qn;
    #2;
    ack = (pn != 0) && (pn <= 2) && (int'(pn) <= DEPTH - mCnt);
    check("pushAck", pushAck, ack);
    check("pushOverflow", pushOverflow, pn > 2);
    popped = (qn > 2) ? 2 : int'(qn);
    if (popped > mCnt) popped = mCnt;
    pushed = (ack && !fl && !rb) ? int'(pn) : 0;
    if (!fl && !rb)
      for (int i = 0; i < popped; i++) check("pop_data", dataOut[i*DW +: DW], exp_q[i]);
`ifdef MULTI_PORT_QUEUE_PROBE_EN
    check("probe_read", probeDataOut, mem[probeIdx]);
`endif
    @(posedge clk);
    if (fl) begin
      mHead = 0; mCnt = 0; exp_q.delete();
    end else if (rb) begin
      mCnt = (int'(rbT) - mHead + DEPTH) % DEPTH;
      while (exp_q.size() > mCnt) void'(exp_q.pop_back());
    end else begin
      for (int i = 0; i < popped; i++) void'(exp_q.pop_front());
      for (int i = 0; i < pushed; i++) begin
        lane = (i == 0) ? d0 : d1;
        mem[(mHead + mCnt + i) % DEPTH] = lane;
        exp_q.push_back(lane);
      end
      mHead = (mHead + popped) % DEPTH;
      mCnt = mCnt + pushed - popped;
    end
`ifdef MULTI_PORT_QUEUE_PROBE_EN
    if (probeReq) begin
      mem[probeIdx] = probeDataIn;
      pos = (int'(probeIdx) - mHead + DEPTH) % DEPTH;
      if (pos < exp_q.size()) exp_q[pos] = probeDataIn;
    end
`else
    pos = 0;
`endif
    #1;
    check_state();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0] pn;
    logic [7:0] d0, d1;
    logic [2:0] qn;
    logic       expAck;
    int         expCount;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{3'd2, 8'hA1, 8'hA2, 3'd0, 1'b1, 2};
    tbl[1] = '{3'd2, 8'hB1, 8'hB2, 3'd0, 1'b1, 4};
    tbl[2] = '{3'd2, 8'hB3, 8'hB4, 3'd0, 1'b1, 6};
    tbl[3] = '{3'd1, 8'hB5, 8'h00, 3'd0, 1'b1, 7};
    tbl[4] = '{3'd2, 8'hC1, 8'hC2, 3'd0, 1'b0, 7};  // needs 2, only 1 free
    tbl[5] = '{3'd1, 8'hC3, 8'h00, 3'd0, 1'b1, 8};
    tbl[6] = '{3'd2, 8'hD1, 8'hD2, 3'd2, 1'b0, 6};  // full: pop frees nothing this cycle
    tbl[7] = '{3'd2, 8'hD3, 8'hD4, 3'd0, 1'b1, 8};
    tbl[8] = '{3'd3, 8'hE1, 8'hE2, 3'd0, 1'b0, 8};  // over-lane push ignored
    tbl[9] = '{3'd0, 8'h00, 8'h00, 3'd3, 1'b0, 6};  // pop request clipped to 2

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_free", freeCount, 8);
    check("rst_dataOut", dataOut, 0);
    check("rst_popValid", popValid, 0);
    reset = 1'b1;
    #1;
    check_state();

    for (int i = 0; i < 10; i++) begin
      flush = 1'b0; rollback = 1'b0;
      pushCount = tbl[i].pn; dataIn = {tbl[i].d1, tbl[i].d0}; popCount = tbl[i].qn;
      #1;
      check("tbl_ack", pushAck, tbl[i].expAck);
      step(0, 0, 0, tbl[i].pn, tbl[i].d0, tbl[i].d1, tbl[i].qn);
      check("tbl_count", count, tbl[i].expCount);
      if (i == 0) begin
        check("s1_tail", tail, 2);
        check("s1_data", dataOut, 16'hA2A1);
        check("s1_valid", popValid, 2'b11);
      end
      if (i == 5) begin
        check("s2_full", full, 1);
        check("s2_afull", afull, 1);
        check("s2_free", freeCount, 0);
      end
    end

    // wrap-around: park head/tail at 6, push across the end of the ring
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2, 8'h10 + 8'(i), 8'h20 + 8'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 2);
    check("s4_head", head, 6);
    check("s4_empty", empty, 1);
    step(0, 0, 0, 2, 8'hF1, 8'hF2, 0);
    step(0, 0, 0, 2, 8'hF3, 8'hF4, 0);
    check("s4_tail", tail, 2);
    check("s4_data0", dataOut, 16'hF2F1);
    step(0, 0, 0, 0, 0, 0, 2);
    check("s4_data1", dataOut, 16'hF4F3);
    step(0, 0, 0, 0, 0, 0, 2);
    check("s4_head2", head, 2);

    // rollback: head=1, tail=5, then roll back to 3 with push and pop asserted
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2, 8'h31, 8'h32, 0);
    step(0, 0, 0, 2, 8'h33, 8'h34, 0);
    step(0, 0, 0, 1, 8'h35, 8'h00, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("s5_pre_count", count, 4);
    step(0, 1, 3, 2, 8'h41, 8'h42, 2);
    check("s5_tail", tail, 3);
    check("s5_count", count, 2);
    check("s5_head", head, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    check("s5_empty", empty, 1);

`ifdef MULTI_PORT_QUEUE_PROBE_EN
    step(0, 0, 0, 2, 8'h51, 8'h52, 0);
    probeReq = 1'b1; probeIdx = 3'd4; probeDataIn = 8'h5A;
    step(0, 0, 0, 0, 0, 0, 0);
    probeReq = 1'b0;
    check("probe_count", count, 2);
    #1;
    check("probe_readback", probeDataOut, 8'h5A);
`endif

    // asynchronous reset between edges
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2, 8'h61, 8'h62, 0);
    step(0, 0, 0, 2, 8'h63, 8'h64, 0);
    step(0, 0, 0, 1, 8'h65, 8'h00, 0);
    check("s6_pre_count", count, 5);
    flush = 1'b0; pushCount = '0; popCount = '0; rollback = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("s6_count", count, 0);
    check("s6_empty", empty, 1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_state();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic fl, rb;
      logic [2:0] rbT;
      fl = ($urandom_range(0, 39) == 0);
      rb = ($urandom_range(0, 15) == 0);
      rbT = 3'((mHead + int'($urandom_range(0, mCnt))) % DEPTH);
`ifdef MULTI_PORT_QUEUE_PROBE_EN
      probeReq = ($urandom_range(0, 7) == 0);
      probeIdx = 3'($urandom_range(0, 7));
      probeDataIn = 8'($urandom_range(0, 255));
`endif
      step(fl, rb, rbT, 3'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 3'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
